pipe_reg_skid: RTL and testbench

PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_sat_cnt.sv | 14 +
 rtl/pipe_reg_skid.sv | 157 +++++++++++++++
 tb/tb_pipe_reg_skid.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the fetch pipeline register.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
    } lane_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: saturating up-counter with synchronous clear.
module pipe_sat_cnt #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk)
        cnt <= clr ? '0 : (inc && cnt != '1) ? cnt + 1'b1 : cnt;

endmodule

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: fetch-stage pipeline register with flush and stall counter.
// Define PIPE_REG_SKID_EN for a skid entry and registered in_ready_o; otherwise single entry.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int           W      = 32,
    parameter int           NLANE  = 1,
    parameter logic [W-1:0] BUBBLE = W'(NOP_INSTR),
    parameter int           CW     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [NLANE-1:0]   in_lane_vld_i,
    input  logic [NLANE*W-1:0] in_pc_i,
    input  logic [NLANE*W-1:0] in_instr_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [NLANE-1:0]   out_lane_vld_o,
    output logic [NLANE*W-1:0] out_pc_o,
    output logic [NLANE*W-1:0] out_instr_o,
    output logic [CW-1:0]      stall_cnt_o
);

    localparam logic [NLANE*W-1:0] BUBBLES = {NLANE{BUBBLE}};

    state_t             state, state_n;
    logic [NLANE-1:0]   vld_q, vld_n;
    logic [NLANE*W-1:0] pc_q, pc_n, instr_q, instr_n, in_instr;
    logic               accept, retire;

    assign out_valid_o    = state != EMPTY;
    assign out_lane_vld_o = vld_q;
    assign out_pc_o       = pc_q;
    assign out_instr_o    = instr_q;
    assign accept         = in_valid_i && in_ready_o;
    assign retire         = out_valid_o && out_ready_i;

    always_comb begin
        in_instr = in_instr_i;
        for (int l = 0; l < NLANE; l++)
            if (!in_lane_vld_i[l]) in_instr[l*W +: W] = BUBBLE;
    end

`ifdef PIPE_REG_SKID_EN
    logic [NLANE-1:0]   skid_vld, skid_vld_n;
    logic [NLANE*W-1:0] skid_pc, skid_pc_n, skid_instr, skid_instr_n;
    logic               rdy_q;

    assign in_ready_o = rdy_q;

    always_comb begin
        state_n      = state;
        vld_n        = vld_q;
        pc_n         = pc_q;
        instr_n      = instr_q;
        skid_vld_n   = skid_vld;
        skid_pc_n    = skid_pc;
        skid_instr_n = skid_instr;
        if (flush_i) begin
            state_n      = EMPTY;
            vld_n        = '0;
            pc_n         = '0;
            instr_n      = BUBBLES;
            skid_vld_n   = '0;
            skid_pc_n    = '0;
            skid_instr_n = BUBBLES;
        end else if (state == SKID) begin
            if (retire) begin
                state_n      = FULL;
                vld_n        = skid_vld;
                pc_n         = skid_pc;
                instr_n      = skid_instr;
                skid_vld_n   = '0;
                skid_pc_n    = '0;
                skid_instr_n = BUBBLES;
            end
        end else if (accept && (state == EMPTY || retire)) begin
            state_n = FULL;
            vld_n   = in_lane_vld_i;
            pc_n    = in_pc_i;
            instr_n = in_instr;
        end else if (accept) begin
            state_n      = SKID;
            skid_vld_n   = in_lane_vld_i;
            skid_pc_n    = in_pc_i;
            skid_instr_n = in_instr;
        end else if (retire) begin
            state_n = EMPTY;
            vld_n   = '0;
            pc_n    = '0;
            instr_n = BUBBLES;
        end
    end

    always_ff @(posedge clk_i)
        if (rst_i) begin
            skid_vld   <= '0;
            skid_pc    <= '0;
            skid_instr <= BUBBLES;
            rdy_q      <= 1'b1;
        end else begin
            skid_vld   <= skid_vld_n;
            skid_pc    <= skid_pc_n;
            skid_instr <= skid_instr_n;
            rdy_q      <= state_n != SKID;
        end
`else
    assign in_ready_o = !out_valid_o || out_ready_i;

    always_comb begin
        state_n = state;
        vld_n   = vld_q;
        pc_n    = pc_q;
        instr_n = instr_q;
        if (flush_i) begin
            state_n = EMPTY;
            vld_n   = '0;
            pc_n    = '0;
            instr_n = BUBBLES;
        end else if (accept) begin
            state_n = FULL;
            vld_n   = in_lane_vld_i;
            pc_n    = in_pc_i;
            instr_n = in_instr;
        end else if (retire) begin
            state_n = EMPTY;
            vld_n   = '0;
            pc_n    = '0;
            instr_n = BUBBLES;
        end
    end
`endif

    always_ff @(posedge clk_i)
        if (rst_i) begin
            state   <= EMPTY;
            vld_q   <= '0;
            pc_q    <= '0;
            instr_q <= BUBBLES;
        end else begin
            state   <= state_n;
            vld_q   <= vld_n;
            pc_q    <= pc_n;
            instr_q <= instr_n;
        end

    pipe_sat_cnt #(.CW(CW)) u_stall (
        .clk(clk_i),
        .clr(rst_i),
        .inc(out_valid_o && !out_ready_i),
        .cnt(stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: directed checks of pipe_reg_skid in both single-entry and skid builds.
module tb_pipe_reg_skid;

    logic clk = 1'b0;
    logic rst;
    int   ncmp = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    logic        a_flush, a_iv, a_irdy, a_ov, a_ordy;
    logic [0:0]  a_ivld, a_ovld;
    logic [31:0] a_pc, a_ins, a_opc, a_oins;
    logic [15:0] a_cnt;

    logic        b_flush, b_iv, b_irdy, b_ov, b_ordy;
    logic [1:0]  b_ivld, b_ovld;
    logic [63:0] b_pc, b_ins, b_opc, b_oins;
    logic [3:0]  b_cnt;

    pipe_reg_skid dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
        .in_valid_i(a_iv), .in_ready_o(a_irdy), .in_lane_vld_i(a_ivld),
        .in_pc_i(a_pc), .in_instr_i(a_ins),
        .out_valid_o(a_ov), .out_ready_i(a_ordy), .out_lane_vld_o(a_ovld),
        .out_pc_o(a_opc), .out_instr_o(a_oins), .stall_cnt_o(a_cnt)
    );

    pipe_reg_skid #(.NLANE(2), .CW(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
        .in_valid_i(b_iv), .in_ready_o(b_irdy), .in_lane_vld_i(b_ivld),
        .in_pc_i(b_pc), .in_instr_i(b_ins),
        .out_valid_o(b_ov), .out_ready_i(b_ordy), .out_lane_vld_o(b_ovld),
        .out_pc_o(b_opc), .out_instr_o(b_oins), .stall_cnt_o(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 0; a_iv = 0; a_ordy = 0; a_ivld = 1'b1; a_pc = '0; a_ins = '0;
        b_flush = 0; b_iv = 0; b_ordy = 0; b_ivld = '0; b_pc = '0; b_ins = '0;
        tick();
        tick();
        chk("rst_ov", a_ov, 0);
        chk("rst_irdy", a_irdy, 1);
        chk("rst_lvld", a_ovld, 0);
        chk("rst_pc", a_opc, 0);
        chk("rst_instr", a_oins, 32'h13);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_b_instr", b_oins, {32'h13, 32'h13});
        rst = 1'b0;

        a_iv = 1; a_pc = 32'h100; a_ins = 32'h00A00093; a_ordy = 1;
        tick();
        a_iv = 0;
        chk("single_ov", a_ov, 1);
        chk("single_pc", a_opc, 32'h100);
        chk("single_instr", a_oins, 32'h00A00093);
        chk("single_lvld", a_ovld, 1);
        chk("single_irdy", a_irdy, 1);
        tick();
        chk("single_drain_ov", a_ov, 0);
        chk("single_drain_lvld", a_ovld, 0);
        chk("single_drain_instr", a_oins, 32'h13);
        chk("single_cnt", a_cnt, 0);

`ifdef PIPE_REG_SKID_EN
        a_ordy = 0; a_iv = 1; a_pc = 32'h200; a_ins = 32'hAAAA_0001;
        tick();
        a_pc = 32'h204; a_ins = 32'hBBBB_0002;
        chk("skid_a_irdy", a_irdy, 1);
        chk("skid_a_pc", a_opc, 32'h200);
        tick();
        a_iv = 0;
        chk("skid_full_irdy", a_irdy, 0);
        chk("skid_hold_pc", a_opc, 32'h200);
        chk("skid_cnt1", a_cnt, 1);
        tick();
        chk("skid_hold_instr", a_oins, 32'hAAAA_0001);
        chk("skid_still_blocked", a_irdy, 0);
        a_ordy = 1;
        tick();
        chk("skid_b_pc", a_opc, 32'h204);
        chk("skid_b_instr", a_oins, 32'hBBBB_0002);
        chk("skid_b_irdy", a_irdy, 1);
        tick();
        chk("skid_empty_ov", a_ov, 0);
        chk("skid_cnt2", a_cnt, 2);
`else
        a_ordy = 0; a_iv = 1; a_pc = 32'h200; a_ins = 32'hAAAA_0001;
        tick();
        a_iv = 0;
        chk("bp_ov", a_ov, 1);
        chk("bp_irdy", a_irdy, 0);
        tick();
        tick();
        chk("bp_cnt2", a_cnt, 2);
        chk("bp_hold_pc", a_opc, 32'h200);
        chk("bp_hold_instr", a_oins, 32'hAAAA_0001);
        a_ordy = 1;
        #1;
        chk("bp_comb_irdy", a_irdy, 1);
        tick();
        chk("bp_retire_ov", a_ov, 0);
        chk("bp_cnt_keep", a_cnt, 2);
`endif

        a_ordy = 1;
        for (int i = 0; i < 4; i++) begin
            a_iv = 1; a_pc = 32'h300 + 32'(4 * i); a_ins = 32'h1000 + 32'(i);
            tick();
            chk("stream_pc", a_opc, 32'h300 + 32'(4 * i));
            chk("stream_instr", a_oins, 32'h1000 + 32'(i));
            chk("stream_irdy", a_irdy, 1);
        end
        a_iv = 0;
        tick();
        chk("stream_end_ov", a_ov, 0);
        chk("stream_cnt", a_cnt, 2);

        a_ordy = 0; a_iv = 1; a_pc = 32'h400; a_ins = 32'hAAAA_0004;
        tick();
        a_pc = 32'h404; a_ins = 32'hBBBB_0004;
        tick();
        a_flush = 1; a_pc = 32'h4FC; a_ins = 32'hCCCC_0004;
        tick();
        a_flush = 0; a_iv = 0;
        chk("flush_ov", a_ov, 0);
        chk("flush_instr", a_oins, 32'h13);
        chk("flush_pc", a_opc, 0);
        chk("flush_lvld", a_ovld, 0);
        chk("flush_irdy", a_irdy, 1);
        a_ordy = 1;
        tick();
        tick();
        chk("flush_nothing_later", a_ov, 0);
        chk("flush_cnt", a_cnt, 4);

        a_ordy = 0; a_iv = 1; a_pc = 32'h500; a_ins = 32'h5;
        tick();
        rst = 1; a_iv = 0;
        tick();
        rst = 0;
        chk("midrst_ov", a_ov, 0);
        chk("midrst_cnt", a_cnt, 0);
        chk("midrst_irdy", a_irdy, 1);
        a_iv = 1; a_pc = 32'h600; a_ins = 32'h6; a_ordy = 1;
        tick();
        a_iv = 0;
        chk("midrst_accept_ov", a_ov, 1);
        chk("midrst_accept_pc", a_opc, 32'h600);

        b_ordy = 0; b_iv = 1; b_ivld = 2'b01;
        b_pc = {32'h104, 32'h100}; b_ins = {32'hDEADBEEF, 32'h00A00093};
        tick();
        b_iv = 0;
        chk("lane_vld", b_ovld, 2'b01);
        chk("lane1_bubble", b_oins[63:32], 32'h13);
        chk("lane0_instr", b_oins[31:0], 32'h00A00093);
        chk("lane0_pc", b_opc[31:0], 32'h100);
        chk("lane_cnt0", b_cnt, 0);
        repeat (14) tick();
        chk("sat_cnt14", b_cnt, 14);
        repeat (6) tick();
        chk("sat_cnt15", b_cnt, 15);
        rst = 1;
        tick();
        rst = 0;
        chk("sat_rst_cnt", b_cnt, 0);
        chk("sat_rst_ov", b_ov, 0);
        chk("sat_rst_instr", b_oins, {32'h13, 32'h13});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
